// File: rtl/smash_noc_ni.sv
// Network interface between a local core and the centre port of a smash_noc router.
// TX FIFO injects into the mesh; RX FIFO collects matching ejections and internal loopback traffic.
module smash_noc_ni #(
   parameter int ADDR_SIZE     = 2,
   parameter int DATA_SIZE     = 32,
   parameter int TX_DEPTH      = 4,
   parameter int RX_DEPTH      = 4,
   parameter int NODE_ROW_ADDR = 0,
   parameter int NODE_COL_ADDR = 0
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_core_valid,
   input  logic [ADDR_SIZE-1:0] i_core_addr_row,
   input  logic [ADDR_SIZE-1:0] i_core_addr_col,
   input  logic [DATA_SIZE-1:0] i_core_data,
   output logic                 o_core_ready,
   output logic                 o_core_valid,
   output logic [DATA_SIZE-1:0] o_core_data,
   input  logic                 i_core_ready,
   output logic                 o_net_valid,
   output logic [ADDR_SIZE-1:0] o_net_addr_row,
   output logic [ADDR_SIZE-1:0] o_net_addr_col,
   output logic [DATA_SIZE-1:0] o_net_data,
   input  logic                 i_net_ready,
   input  logic                 i_net_valid,
   input  logic [ADDR_SIZE-1:0] i_net_addr_row,
   input  logic [ADDR_SIZE-1:0] i_net_addr_col,
   input  logic [DATA_SIZE-1:0] i_net_data,
   output logic                 o_net_ready,
   output logic [15:0]          o_tx_count,
   output logic [15:0]          o_rx_count,
   output logic [15:0]          o_drop_count
);

   localparam int TX_PW = $clog2(TX_DEPTH);
   localparam int RX_PW = $clog2(RX_DEPTH);
   localparam logic [ADDR_SIZE-1:0] OWN_ROW = ADDR_SIZE'(NODE_ROW_ADDR);
   localparam logic [ADDR_SIZE-1:0] OWN_COL = ADDR_SIZE'(NODE_COL_ADDR);

   function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
      if (en && cnt != 16'hFFFF)
         return cnt + 16'd1;
      return cnt;
   endfunction

   logic [ADDR_SIZE-1:0] tx_row_mem [TX_DEPTH];
   logic [ADDR_SIZE-1:0] tx_col_mem [TX_DEPTH];
   logic [DATA_SIZE-1:0] tx_data_mem [TX_DEPTH];
   logic [TX_PW-1:0]     tx_wr_ptr, tx_rd_ptr;
   logic [TX_PW:0]       tx_cnt;

   logic [DATA_SIZE-1:0] rx_data_mem [RX_DEPTH];
   logic [RX_PW-1:0]     rx_wr_ptr, rx_rd_ptr;
   logic [RX_PW:0]       rx_cnt;

   logic                 tx_full, tx_empty, rx_full, rx_empty;
   logic [ADDR_SIZE-1:0] head_row, head_col;
   logic [DATA_SIZE-1:0] head_data, rx_wdata;
   logic                 head_local, net_offer, loop_mv;
   logic                 net_accept, net_wr, net_drop;
   logic                 tx_push, tx_pop, rx_wr, rx_pop;

   // Depths are powers of two, so the count MSB alone flags a full FIFO.
   assign tx_full  = tx_cnt[TX_PW];
   assign tx_empty = (tx_cnt == '0);
   assign rx_full  = rx_cnt[RX_PW];
   assign rx_empty = (rx_cnt == '0);

   assign head_row   = tx_row_mem[tx_rd_ptr];
   assign head_col   = tx_col_mem[tx_rd_ptr];
   assign head_data  = tx_data_mem[tx_rd_ptr];
   assign head_local = (head_row == OWN_ROW) && (head_col == OWN_COL);
   assign net_offer  = !tx_empty && !head_local;

   assign net_accept = i_net_valid && !rx_full;
   assign net_wr     = net_accept && (i_net_addr_row == OWN_ROW) && (i_net_addr_col == OWN_COL);
   assign net_drop   = net_accept && !net_wr;
   // Network ejections win the RX write port; a local head waits a cycle.
   assign loop_mv    = !tx_empty && head_local && !rx_full && !net_wr;

   assign tx_push  = i_core_valid && !tx_full;
   assign tx_pop   = (net_offer && i_net_ready) || loop_mv;
   assign rx_wr    = net_wr || loop_mv;
   assign rx_wdata = net_wr ? i_net_data : head_data;
   assign rx_pop   = !rx_empty && i_core_ready;

   assign o_core_ready   = !tx_full;
   assign o_net_valid    = net_offer;
   assign o_net_addr_row = net_offer ? head_row  : '0;
   assign o_net_addr_col = net_offer ? head_col  : '0;
   assign o_net_data     = net_offer ? head_data : '0;
   assign o_net_ready    = !rx_full;
   assign o_core_valid   = !rx_empty;
   assign o_core_data    = rx_empty ? '0 : rx_data_mem[rx_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (tx_push) begin
         tx_row_mem[tx_wr_ptr]  <= i_core_addr_row;
         tx_col_mem[tx_wr_ptr]  <= i_core_addr_col;
         tx_data_mem[tx_wr_ptr] <= i_core_data;
      end
      if (rx_wr)
         rx_data_mem[rx_wr_ptr] <= rx_wdata;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tx_wr_ptr    <= '0;
         tx_rd_ptr    <= '0;
         tx_cnt       <= '0;
         rx_wr_ptr    <= '0;
         rx_rd_ptr    <= '0;
         rx_cnt       <= '0;
         o_tx_count   <= '0;
         o_rx_count   <= '0;
         o_drop_count <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_PW'(1);
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_PW'(1);
         if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + (TX_PW+1)'(1);
         else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - (TX_PW+1)'(1);

         if (rx_wr)  rx_wr_ptr <= rx_wr_ptr + RX_PW'(1);
         if (rx_pop) rx_rd_ptr <= rx_rd_ptr + RX_PW'(1);
         if (rx_wr && !rx_pop)      rx_cnt <= rx_cnt + (RX_PW+1)'(1);
         else if (!rx_wr && rx_pop) rx_cnt <= rx_cnt - (RX_PW+1)'(1);

         o_tx_count   <= sat_inc(o_tx_count, net_offer && i_net_ready);
         o_rx_count   <= sat_inc(o_rx_count, rx_wr);
         o_drop_count <= sat_inc(o_drop_count, net_drop);
      end
   end

endmodule

// File: tb/tb_smash_noc_ni.sv
// Directed bench for smash_noc_ni at node (0,0): injection, backpressure, loopback,
// RX-port contention, misroute drop, RX full and asynchronous reset.
module tb_smash_noc_ni;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        core_valid_in, core_ready_in, net_ready_in, net_valid_in;
   logic [1:0]  core_row, core_col, net_row_in, net_col_in;
   logic [31:0] core_data_in, net_data_in;
   logic        core_ready, core_valid, net_valid, net_ready;
   logic [31:0] core_data, net_data;
   logic [1:0]  net_row, net_col;
   logic [15:0] tx_count, rx_count, drop_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   smash_noc_ni dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_core_valid(core_valid_in), .i_core_addr_row(core_row), .i_core_addr_col(core_col),
      .i_core_data(core_data_in), .o_core_ready(core_ready),
      .o_core_valid(core_valid), .o_core_data(core_data), .i_core_ready(core_ready_in),
      .o_net_valid(net_valid), .o_net_addr_row(net_row), .o_net_addr_col(net_col),
      .o_net_data(net_data), .i_net_ready(net_ready_in),
      .i_net_valid(net_valid_in), .i_net_addr_row(net_row_in), .i_net_addr_col(net_col_in),
      .i_net_data(net_data_in), .o_net_ready(net_ready),
      .o_tx_count(tx_count), .o_rx_count(rx_count), .o_drop_count(drop_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      core_valid_in = 0; core_ready_in = 0; net_ready_in = 0; net_valid_in = 0;
      core_row = 0; core_col = 0; core_data_in = 0;
      net_row_in = 0; net_col_in = 0; net_data_in = 0;
      step(); step();
      chk("rst_core_ready", core_ready, 1);
      chk("rst_net_ready", net_ready, 1);
      chk("rst_net_valid", net_valid, 0);
      chk("rst_core_valid", core_valid, 0);
      chk("rst_net_data", net_data, 0);
      chk("rst_core_data", core_data, 0);
      chk("rst_tx_count", tx_count, 0);
      rst_n = 1'b1;
      step();

      // 1: single remote packet
      core_valid_in = 1; core_row = 1; core_col = 1; core_data_in = 32'hDEADBEEF;
      net_ready_in = 1;
      step();
      core_valid_in = 0;
      chk("t1_net_valid", net_valid, 1);
      chk("t1_net_row", net_row, 1);
      chk("t1_net_col", net_col, 1);
      chk("t1_net_data", net_data, 32'hDEADBEEF);
      step();
      chk("t1_tx_count", tx_count, 1);
      chk("t1_net_valid_low", net_valid, 0);
      chk("t1_net_data_zero", net_data, 0);

      // 2: backpressure, five pushes into four entries
      net_ready_in = 0;
      core_row = 2; core_col = 3;
      for (int i = 0; i < 5; i++) begin
         core_valid_in = 1; core_data_in = 32'h100 + i;
         step();
         chk($sformatf("t2_core_ready_%0d", i), core_ready, (i >= 3) ? 0 : 1);
         chk($sformatf("t2_net_hold_%0d", i), net_data, 32'h100);
      end
      core_valid_in = 0;
      net_ready_in = 1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t2_order_%0d", k), net_data, 32'h100 + k);
         step();
         chk($sformatf("t2_ready_back_%0d", k), core_ready, 1);
      end
      chk("t2_net_valid_low", net_valid, 0);
      chk("t2_tx_count", tx_count, 5);   // 1 from test 1 plus 4 here

      // 3: loopback
      core_valid_in = 1; core_row = 0; core_col = 0; core_data_in = 32'h1234;
      step();
      core_valid_in = 0;
      chk("t3_net_valid", net_valid, 0);
      chk("t3_core_valid_early", core_valid, 0);
      step();
      chk("t3_core_valid", core_valid, 1);
      chk("t3_core_data", core_data, 32'h1234);
      chk("t3_rx_count", rx_count, 1);
      chk("t3_tx_count", tx_count, 5);
      core_ready_in = 1;
      step();
      core_ready_in = 0;
      chk("t3_core_valid_pop", core_valid, 0);
      chk("t3_core_data_zero", core_data, 0);

      // 4: loopback head and network ejection compete for the RX FIFO
      core_valid_in = 1; core_row = 0; core_col = 0; core_data_in = 32'h5555;
      step();
      core_valid_in = 0;
      net_valid_in = 1; net_row_in = 0; net_col_in = 0; net_data_in = 32'hA5A5;
      step();
      net_valid_in = 0;
      chk("t4_rx_count_net", rx_count, 2);
      chk("t4_first_data", core_data, 32'hA5A5);
      step();
      chk("t4_rx_count_loop", rx_count, 3);
      chk("t4_head_stable", core_data, 32'hA5A5);
      core_ready_in = 1;
      step();
      chk("t4_second_data", core_data, 32'h5555);
      step();
      core_ready_in = 0;
      chk("t4_drained", core_valid, 0);

      // 5: misrouted ejection is dropped
      net_valid_in = 1; net_row_in = 1; net_col_in = 0; net_data_in = 32'hBAD;
      chk("t5_net_ready", net_ready, 1);
      step();
      net_valid_in = 0;
      chk("t5_drop_count", drop_count, 1);
      chk("t5_core_valid", core_valid, 0);
      chk("t5_rx_count", rx_count, 3);

      // 6: fill RX, hold a TX packet, then reset asynchronously
      net_row_in = 0; net_col_in = 0; net_valid_in = 1;
      for (int i = 0; i < 4; i++) begin
         net_data_in = 32'h10 + i;
         step();
      end
      chk("t6_net_ready_full", net_ready, 0);
      chk("t6_core_data", core_data, 32'h10);
      chk("t6_rx_count", rx_count, 7);
      net_data_in = 32'h99;
      net_ready_in = 0;
      core_valid_in = 1; core_row = 3; core_col = 3; core_data_in = 32'h77;
      step();
      core_valid_in = 0;
      chk("t6_no_overflow", rx_count, 7);
      chk("t6_tx_pending", net_valid, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_async_net_ready", net_ready, 1);
      chk("t6_async_core_valid", core_valid, 0);
      chk("t6_async_net_valid", net_valid, 0);
      chk("t6_async_core_ready", core_ready, 1);
      chk("t6_async_rx_count", rx_count, 0);
      chk("t6_async_tx_count", tx_count, 0);
      chk("t6_async_drop_count", drop_count, 0);
      net_valid_in = 0;
      step();
      rst_n = 1'b1;
      step(); step();
      chk("t6_after_core_valid", core_valid, 0);
      chk("t6_after_net_valid", net_valid, 0);
      chk("t6_after_core_data", core_data, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
